// File: rtl/dcache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dcache_pkg                                                      |
// | Purpose  : Shared definitions for the 2-way set-associative data cache:    |
// |            controller state encoding and geometry helper functions.        |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    MISS        = 3'd1,
    WRITEBACK   = 3'd2,
    REFILL      = 3'd3,
    REFILL_DONE = 3'd4,
    FLUSH_SCAN  = 3'd5,
    FLUSH_WB    = 3'd6
  } state_t;

  // Number of byte-offset bits inside one line.
  function automatic int calc_off(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  // Number of CPU words per line.
  function automatic int calc_words(input int line_w, input int word_w);
    return line_w / word_w;
  endfunction

  // Tag width: whatever is left above index and offset.
  function automatic int calc_tag_w(input int addr_w, input int line_w, input int set_bits);
    return addr_w - calc_off(line_w) - set_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_way.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dcache_way                                                      |
// | Purpose  : Storage for one way of the cache: per-set valid, dirty, tag and |
// |            line data. Asynchronous read port, synchronous write port.      |
// | Ports    : clk, rst_n          - clock, async active-low clear of v/d bits |
// |            rd_idx              - set index for the read port               |
// |            rd_valid/rd_dirty/rd_tag/rd_data - read port contents           |
// |            wr_en, wr_idx       - line write strobe and set index           |
// |            wr_dirty/wr_tag/wr_data - written line (valid is always set)    |
// |            clr_all             - invalidate every set of this way          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dcache_way #(
  parameter int TAG_W    = 23,
  parameter int LINE_W   = 256,
  parameter int SET_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SET_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [LINE_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [SET_BITS-1:0] wr_idx,
  input  logic                wr_dirty,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [LINE_W-1:0]   wr_data,
  input  logic                clr_all
);

  localparam int SETS = 1 << SET_BITS;

  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   dirty;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  // Only the state bits are reset; tag/data contents are meaningless while
  // the line is invalid, so they live in plain (RAM-friendly) storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (clr_all) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/dcache_2way_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dcache_2way_top                                                 |
// | Purpose  : 2-way set-associative, write-back, write-allocate L1 data cache |
// |            controller with per-set LRU and whole-cache flush.              |
// | Ports    : clk_i, rst_i        - clock, async active-low reset             |
// |            p1_*                - CPU data port (req, addr, data, stall)    |
// |            flush_i/flush_done_o - flush pulse in, completion pulse out     |
// |            mem_*               - line-wide memory port with one-cycle ack  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dcache_2way_top
  import dcache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int WORD_W   = 32,
  parameter int LINE_W   = 256,
  parameter int SET_BITS = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic              flush_i,
  output logic              flush_done_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);

  localparam int OFF      = calc_off(LINE_W);
  localparam int WORDS    = calc_words(LINE_W, WORD_W);
  localparam int TAG_W    = calc_tag_w(ADDR_W, LINE_W, SET_BITS);
  localparam int WSEL_W   = $clog2(WORDS);
  localparam int BYTE_OFF = $clog2(WORD_W / 8);
  localparam int SETS     = 1 << SET_BITS;
  // Flush counter is {set, way} plus one extra bit so it can reach 2*SETS,
  // which marks "every entry visited" even when the last entry needed a write-back.
  localparam int              CNT_W   = SET_BITS + 2;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(2 * SETS);

  state_t state, state_nxt;

  // Request decode
  logic                req;
  logic [TAG_W-1:0]    req_tag;
  logic [SET_BITS-1:0] req_idx;
  logic [WSEL_W-1:0]   wsel;

  assign req     = p1_MemRead_i | p1_MemWrite_i;
  assign req_tag = p1_addr_i[ADDR_W-1:OFF+SET_BITS];
  assign req_idx = p1_addr_i[OFF+SET_BITS-1:OFF];
  assign wsel    = p1_addr_i[OFF-1:BYTE_OFF];

  logic unused_byte_bits;
  assign unused_byte_bits = &{1'b0, p1_addr_i[BYTE_OFF-1:0]};

  // Miss context, captured when the miss is detected so the transfer
  // completes consistently even if the CPU drops its request.
  logic [TAG_W-1:0]    miss_tag;
  logic [SET_BITS-1:0] miss_idx;
  logic                miss_way;

  logic [CNT_W-1:0]    flush_cnt;
  logic [SET_BITS-1:0] flush_idx;
  logic                flush_way;
  logic                flushing;

  logic [SETS-1:0] lru;
  logic            ack_q;
  logic            mem_go;

  // Way storage interface
  logic [SET_BITS-1:0] rd_idx;
  logic [1:0]          way_valid;
  logic [1:0]          way_dirty;
  logic [TAG_W-1:0]    way_tag  [2];
  logic [LINE_W-1:0]   way_data [2];
  logic [1:0]          way_we;
  logic [SET_BITS-1:0] wr_idx;
  logic                wr_dirty;
  logic [TAG_W-1:0]    wr_tag;
  logic [LINE_W-1:0]   wr_data;
  logic                clr_all;

  assign flush_idx = flush_cnt[SET_BITS:1];
  assign flush_way = flush_cnt[0];
  assign flushing  = (state == FLUSH_SCAN) || (state == FLUSH_WB);

  // Single shared read index: the CPU set in IDLE, the latched miss set while
  // servicing a miss, the scan position while flushing.
  always_comb begin
    rd_idx = miss_idx;
    if (state == IDLE) rd_idx = req_idx;
    else if (flushing) rd_idx = flush_idx;
  end

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way #(
      .TAG_W    (TAG_W),
      .LINE_W   (LINE_W),
      .SET_BITS (SET_BITS)
    ) u_way (
      .clk      (clk_i),
      .rst_n    (rst_i),
      .rd_idx   (rd_idx),
      .rd_valid (way_valid[w]),
      .rd_dirty (way_dirty[w]),
      .rd_tag   (way_tag[w]),
      .rd_data  (way_data[w]),
      .wr_en    (way_we[w]),
      .wr_idx   (wr_idx),
      .wr_dirty (wr_dirty),
      .wr_tag   (wr_tag),
      .wr_data  (wr_data),
      .clr_all  (clr_all)
    );
  end

  // Lookup is only meaningful in IDLE, where the read port is on the CPU set.
  logic hit0, hit1, hit, hit_way, victim_way;

  assign hit0    = (state == IDLE) && way_valid[0] && (way_tag[0] == req_tag);
  assign hit1    = (state == IDLE) && way_valid[1] && (way_tag[1] == req_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;

  assign victim_way = !way_valid[0] ? 1'b0 :
                      !way_valid[1] ? 1'b1 : lru[req_idx];

  // Line currently under consideration by whichever activity owns the port.
  logic              sel_way;
  logic [LINE_W-1:0] cur_line;
  logic [TAG_W-1:0]  cur_tag;
  logic              cur_valid;
  logic              cur_dirty;

  always_comb begin
    sel_way = miss_way;
    if (state == IDLE) sel_way = hit_way;
    else if (flushing) sel_way = flush_way;
  end

  assign cur_line  = way_data[sel_way];
  assign cur_tag   = way_tag[sel_way];
  assign cur_valid = way_valid[sel_way];
  assign cur_dirty = way_dirty[sel_way];

  assign p1_data_o  = way_data[hit_way][wsel*WORD_W +: WORD_W];
  assign p1_stall_o = (state != IDLE) || (req && !hit);

  // The cycle right after an ack never requests, so every transfer is
  // separated from the next by at least one idle cycle.
  assign mem_go = !ack_q;

  logic [LINE_W-1:0] merged;

  always_comb begin
    state_nxt    = state;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = cur_line;
    flush_done_o = 1'b0;
    way_we       = '0;
    wr_idx       = rd_idx;
    wr_tag       = cur_tag;
    wr_data      = cur_line;
    wr_dirty     = 1'b0;
    clr_all      = 1'b0;
    merged       = cur_line;
    merged[wsel*WORD_W +: WORD_W] = p1_data_i;

    case (state)
      IDLE: begin
        if (flush_i)          state_nxt = FLUSH_SCAN;
        else if (req && !hit) state_nxt = MISS;
        if (req && hit && p1_MemWrite_i) begin
          way_we[hit_way] = 1'b1;
          wr_tag          = req_tag;
          wr_data         = merged;
          wr_dirty        = 1'b1;
        end
      end

      MISS: begin
        state_nxt = (cur_valid && cur_dirty) ? WRITEBACK : REFILL;
      end

      WRITEBACK: begin
        mem_enable_o = mem_go;
        mem_write_o  = 1'b1;
        mem_addr_o   = {cur_tag, miss_idx, {OFF{1'b0}}};
        if (mem_go && mem_ack_i) state_nxt = REFILL;
      end

      REFILL: begin
        mem_enable_o = mem_go;
        mem_addr_o   = {miss_tag, miss_idx, {OFF{1'b0}}};
        if (mem_go && mem_ack_i) begin
          way_we[miss_way] = 1'b1;
          wr_tag           = miss_tag;
          wr_data          = mem_data_i;
          state_nxt        = REFILL_DONE;
        end
      end

      REFILL_DONE: begin
        state_nxt = IDLE;
      end

      FLUSH_SCAN: begin
        if (flush_cnt == CNT_END) begin
          clr_all      = 1'b1;
          flush_done_o = 1'b1;
          state_nxt    = IDLE;
        end else if (cur_valid && cur_dirty) begin
          state_nxt = FLUSH_WB;
        end
      end

      FLUSH_WB: begin
        mem_enable_o = mem_go;
        mem_write_o  = 1'b1;
        mem_addr_o   = {cur_tag, flush_idx, {OFF{1'b0}}};
        if (mem_go && mem_ack_i) begin
          way_we[flush_way] = 1'b1;   // rewrite same tag/data, dirty cleared
          state_nxt         = FLUSH_SCAN;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      lru       <= '0;
      ack_q     <= 1'b0;
      flush_cnt <= '0;
      miss_tag  <= '0;
      miss_idx  <= '0;
      miss_way  <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= mem_enable_o & mem_ack_i;

      if (state == IDLE && req && hit) lru[req_idx] <= ~hit_way;
      if (clr_all) lru <= '0;

      if (state == IDLE && !flush_i && req && !hit) begin
        miss_tag <= req_tag;
        miss_idx <= req_idx;
        miss_way <= victim_way;
      end

      if (state == IDLE)
        flush_cnt <= '0;
      else if ((state == FLUSH_SCAN || state == FLUSH_WB) && state_nxt == FLUSH_SCAN)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_2way_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dcache_2way_top                                              |
// | Purpose  : Directed self-checking bench for dcache_2way_top: cold miss,    |
// |            write hit, way fill, LRU eviction with write-back, flush and    |
// |            reset during refill.                                            |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dcache_2way_top;
  import dcache_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  p1_data_i = '0;
  logic [31:0]  p1_addr_i = '0;
  logic         p1_MemRead_i = 1'b0;
  logic         p1_MemWrite_i = 1'b0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         flush_i = 1'b0;
  logic         flush_done_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;

  int tests_run = 0;
  int tests_failed = 0;

  dcache_2way_top #(
    .ADDR_W(32), .WORD_W(32), .LINE_W(256), .SET_BITS(4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_data_i     (p1_data_i),
    .p1_addr_i     (p1_addr_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .flush_i       (flush_i),
    .flush_done_o  (flush_done_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i),
    .mem_data_o    (mem_data_o),
    .mem_addr_o    (mem_addr_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i)
    if (rst_i) assert (!(dut.hit0 && dut.hit1)) else $error("FAIL double_hit: both ways hit");

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic wait_mem_req(input string tag);
    int n = 0;
    while (!mem_enable_o && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    check_eq({tag, "_req"}, 32'(mem_enable_o), 32'd1);
  endtask

  task automatic mem_service(input string tag, input logic exp_wr, input logic [31:0] exp_addr,
                             input logic [255:0] fill, output logic [255:0] wb_line);
    wait_mem_req(tag);
    check_eq({tag, "_wr"}, 32'(mem_write_o), 32'(exp_wr));
    check_eq({tag, "_addr"}, mem_addr_o, exp_addr);
    wb_line    = mem_data_o;
    mem_data_i = fill;
    mem_ack_i  = 1'b1;
    @(negedge clk_i);
    check_eq({tag, "_en_drop"}, 32'(mem_enable_o), 32'd0);
    mem_ack_i = 1'b0;
  endtask

  task automatic wait_no_stall(input string tag);
    int n = 0;
    while (p1_stall_o && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    check_eq({tag, "_unstall"}, 32'(p1_stall_o), 32'd0);
  endtask

  task automatic cpu_set(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    p1_addr_i     = addr;
    p1_data_i     = data;
  endtask

  logic [255:0] line1, line2, line3, line5, wb;
  int done_cnt, extra_en;

  initial begin
    line1 = mk_line(32'hDEADBEEF);
    line2 = mk_line(32'hCAFE0000);
    line3 = mk_line(32'h44004400);
    line5 = mk_line(32'h000000A0);

    // Reset state
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("rst_stall", 32'(p1_stall_o), 32'd0);
    check_eq("rst_mem_en", 32'(mem_enable_o), 32'd0);
    check_eq("rst_mem_wr", 32'(mem_write_o), 32'd0);
    check_eq("rst_flush_done", 32'(flush_done_o), 32'd0);
    rst_i = 1'b1;

    // Test 1: cold read miss of 0x400
    @(negedge clk_i);
    cpu_set(1, 0, 32'h400, 0);
    #1;
    check_eq("t1_cold_stall", 32'(p1_stall_o), 32'd1);
    mem_service("t1_fill", 1'b0, 32'h400, line1, wb);
    wait_no_stall("t1");
    check_eq("t1_rdata", p1_data_o, 32'hDEADBEEF);

    // Test 2: write hit to 0x404, then read back
    @(negedge clk_i);
    cpu_set(0, 1, 32'h404, 32'h12345678);
    #1;
    check_eq("t2_wr_stall", 32'(p1_stall_o), 32'd0);
    check_eq("t2_wr_mem_en", 32'(mem_enable_o), 32'd0);
    @(negedge clk_i);
    cpu_set(1, 0, 32'h404, 0);
    #1;
    check_eq("t2_rd_stall", 32'(p1_stall_o), 32'd0);
    check_eq("t2_rd_word1", p1_data_o, 32'h12345678);
    p1_addr_i = 32'h400;
    #1;
    check_eq("t2_rd_word0", p1_data_o, 32'hDEADBEEF);

    // Test 3: second tag in set 0 fills way1, no write-back
    @(negedge clk_i);
    cpu_set(1, 0, 32'h400, 0);
    #1;
    check_eq("t3_hit_400", 32'(p1_stall_o), 32'd0);
    @(negedge clk_i);
    cpu_set(1, 0, 32'h2400, 0);
    #1;
    check_eq("t3_miss_stall", 32'(p1_stall_o), 32'd1);
    mem_service("t3_fill", 1'b0, 32'h2400, line2, wb);
    wait_no_stall("t3");
    check_eq("t3_rdata_2400", p1_data_o, 32'hCAFE0000);
    @(negedge clk_i);
    cpu_set(1, 0, 32'h400, 0);
    #1;
    check_eq("t3_rehit_400_stall", 32'(p1_stall_o), 32'd0);
    check_eq("t3_rehit_400_data", p1_data_o, 32'hDEADBEEF);
    @(negedge clk_i);
    cpu_set(1, 0, 32'h2400, 0);
    #1;
    check_eq("t3_rehit_2400_stall", 32'(p1_stall_o), 32'd0);
    check_eq("t3_rehit_2400_data", p1_data_o, 32'hCAFE0000);

    // Test 4: LRU evicts dirty 0x400, write-back then refill 0x4400
    @(negedge clk_i);
    cpu_set(1, 0, 32'h4400, 0);
    mem_service("t4_wb", 1'b1, 32'h400, '0, wb);
    check_eq("t4_wb_word0", wb[31:0], 32'hDEADBEEF);
    check_eq("t4_wb_word1", wb[63:32], 32'h12345678);
    check_eq("t4_wb_word2", wb[95:64], 32'hDEADBEF1);
    mem_service("t4_fill", 1'b0, 32'h4400, line3, wb);
    wait_no_stall("t4");
    check_eq("t4_rdata_4400", p1_data_o, 32'h44004400);
    @(negedge clk_i);
    cpu_set(1, 0, 32'h2400, 0);
    #1;
    check_eq("t4_hit_2400_stall", 32'(p1_stall_o), 32'd0);
    check_eq("t4_hit_2400_data", p1_data_o, 32'hCAFE0000);

    // Test 5: dirty lines in sets 0 and 5, then flush
    @(negedge clk_i);
    cpu_set(0, 1, 32'h2404, 32'hAAAA5555);
    #1;
    check_eq("t5_wr_2404_stall", 32'(p1_stall_o), 32'd0);
    @(negedge clk_i);
    cpu_set(0, 1, 32'h0A0, 32'h5A5A5A5A);
    #1;
    check_eq("t5_wmiss_stall", 32'(p1_stall_o), 32'd1);
    mem_service("t5_fill_a0", 1'b0, 32'h0A0, line5, wb);
    wait_no_stall("t5_wmiss");
    @(negedge clk_i);
    cpu_set(0, 0, 0, 0);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    mem_service("t5_flush_wb0", 1'b1, 32'h2400, '0, wb);
    check_eq("t5_flush_wb0_word1", wb[63:32], 32'hAAAA5555);
    check_eq("t5_flush_wb0_word0", wb[31:0], 32'hCAFE0000);
    mem_service("t5_flush_wb1", 1'b1, 32'h0A0, '0, wb);
    check_eq("t5_flush_wb1_word0", wb[31:0], 32'h5A5A5A5A);
    check_eq("t5_flush_wb1_word1", wb[63:32], 32'h000000A1);
    done_cnt = 0;
    extra_en = 0;
    for (int i = 0; i < 80; i++) begin
      if (flush_done_o) done_cnt++;
      if (mem_enable_o) extra_en++;
      @(negedge clk_i);
    end
    check_eq("t5_flush_done_pulses", 32'(done_cnt), 32'd1);
    check_eq("t5_flush_extra_req", 32'(extra_en), 32'd0);
    cpu_set(1, 0, 32'h2400, 0);
    #1;
    check_eq("t5_post_flush_miss", 32'(p1_stall_o), 32'd1);
    mem_service("t5_refill_2400", 1'b0, 32'h2400, line2, wb);
    wait_no_stall("t5_refill");
    check_eq("t5_rdata_2400", p1_data_o, 32'hCAFE0000);
    @(negedge clk_i);
    cpu_set(1, 0, 32'h400, 0);
    #1;
    check_eq("t5_miss_400", 32'(p1_stall_o), 32'd1);
    mem_service("t5_refill_400", 1'b0, 32'h400, line1, wb);
    wait_no_stall("t5_refill_400");
    check_eq("t5_rdata_400", p1_data_o, 32'hDEADBEEF);

    // Test 6: reset in the middle of a refill
    @(negedge clk_i);
    cpu_set(1, 0, 32'h4400, 0);
    wait_mem_req("t6");
    check_eq("t6_refill_wr", 32'(mem_write_o), 32'd0);
    check_eq("t6_refill_addr", mem_addr_o, 32'h4400);
    rst_i = 1'b0;
    #1;
    check_eq("t6_rst_mem_en", 32'(mem_enable_o), 32'd0);
    check_eq("t6_rst_state", 32'(dut.state), 32'(IDLE));
    check_eq("t6_rst_stall", 32'(p1_stall_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    mem_service("t6_refill_again", 1'b0, 32'h4400, line3, wb);
    wait_no_stall("t6");
    check_eq("t6_rdata", p1_data_o, 32'h44004400);

    @(negedge clk_i);
    cpu_set(0, 0, 0, 0);
    @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
